// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: receive-path state encoding, default framing parameters and output bundle
// shared by the RX sequencer and the packet decoder.
package usb_rx_pkg;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_e;
    localparam int RX_SYNC_MIN  = 5;
    localparam int RX_STUFF_RUN = 6;
    localparam int RX_EOP_SE0   = 2;
    localparam int RX_TIMEOUT   = 255;
    typedef struct packed {
        logic nrzi_clr;
        logic bit_out;
        logic bit_valid;
        logic pkt_start;
        logic pkt_done;
        logic err_stuff;
        logic err_align;
        logic err_tmo;
        logic busy;
    } rx_out_t;
endpackage

// File: rtl/usb_rx_seq_if.sv
// usb_rx_seq_if: decoded-bit input side and framed payload/status output side of the RX sequencer.
interface usb_rx_seq_if;
    logic dec_bit;
    logic dec_valid;
    logic se0;
    logic nrzi_clr;
    logic bit_out;
    logic bit_valid;
    logic pkt_start;
    logic pkt_done;
    logic err_stuff;
    logic err_align;
    logic err_tmo;
    logic busy;
    modport master (
        output dec_bit, dec_valid, se0,
        input  nrzi_clr, bit_out, bit_valid, pkt_start, pkt_done, err_stuff, err_align, err_tmo, busy
    );
    modport slave (
        input  dec_bit, dec_valid, se0,
        output nrzi_clr, bit_out, bit_valid, pkt_start, pkt_done, err_stuff, err_align, err_tmo, busy
    );
endinterface

// File: rtl/usb_unstuff_cnt.sv
// usb_unstuff_cnt: counts consecutive ones; after RUN ones the next bit must be a stuffed 0
// (drop) and a 1 there is a stuffing violation (viol).
module usb_unstuff_cnt
    import usb_rx_pkg::*;
#(
    parameter int RUN = RX_STUFF_RUN
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic vld,
    input  logic din,
    output logic drop,
    output logic viol
);
    localparam logic [2:0] RUN_C = 3'(RUN);
    logic [2:0] ones_q, ones_d;
    logic at_run;
    always_comb begin
        at_run = ones_q == RUN_C;
        drop   = vld && at_run && !din;
        viol   = vld && at_run && din;
        ones_d = clr ? 3'd0 : !vld ? ones_q : (at_run || !din) ? 3'd0 : ones_q + 3'd1;
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) ones_q <= '0;
        else        ones_q <= ones_d;
    end
endmodule

// File: rtl/usb_rx_seq.sv
// usb_rx_seq: frames the NRZI-decoded bitstream into packets (SYNC hunt, unstuffing, SE0 EOP)
// and reports start/done/stuff/alignment/timeout events; every output is registered.
module usb_rx_seq
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN  = RX_SYNC_MIN,
    parameter int STUFF_RUN = RX_STUFF_RUN,
    parameter int EOP_SE0   = RX_EOP_SE0,
    parameter int TIMEOUT   = RX_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          enable,
    usb_rx_seq_if.slave   rx
);
    localparam logic [2:0] SMIN     = 3'(SYNC_MIN);
    localparam logic [1:0] ESE0     = 2'(EOP_SE0);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    rx_state_e  state_q, state_d;
    logic [2:0] zcnt_q, zcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [1:0] s0cnt_q, s0cnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    rx_out_t    out_q, out_d;
    logic       dv, ev, active, tmo, drop, viol;
    usb_unstuff_cnt #(.RUN(STUFF_RUN)) u_unstuff (
        .clk  (clk),
        .rst_b(rst_b),
        .clr  (!enable || state_q != DATA),
        .vld  (dv),
        .din  (rx.dec_bit),
        .drop (drop),
        .viol (viol)
    );
    // dv is a real data bit-time: an SE0 in the same bit-time wins and the bit is ignored
    always_comb begin
        dv      = rx.dec_valid && !rx.se0;
        ev      = rx.dec_valid || rx.se0;
        active  = state_q inside {SYNC, DATA, EOP};
        tmo     = active && !ev && tcnt_q == TMO_LAST;
        state_d = state_q;
        zcnt_d  = zcnt_q;
        bcnt_d  = bcnt_q;
        s0cnt_d = s0cnt_q;
        tcnt_d  = (active && !ev) ? tcnt_q + 8'd1 : 8'd0;
        out_d   = '0;
        if (!enable) begin
            state_d = IDLE;
            zcnt_d  = '0;
            bcnt_d  = '0;
            s0cnt_d = '0;
            tcnt_d  = '0;
        end else if (tmo) begin
            state_d       = ERR;
            s0cnt_d       = '0;
            tcnt_d        = '0;
            out_d.err_tmo = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (dv && !rx.dec_bit) begin
                    state_d        = SYNC;
                    zcnt_d         = 3'd1;
                    out_d.nrzi_clr = 1'b1;
                end
                SYNC: if (rx.se0) state_d = IDLE;
                    else if (rx.dec_valid) begin
                        if (!rx.dec_bit) zcnt_d = (zcnt_q == 3'd7) ? 3'd7 : zcnt_q + 3'd1;
                        else if (zcnt_q >= SMIN) begin
                            state_d         = DATA;
                            bcnt_d          = '0;
                            out_d.pkt_start = 1'b1;
                        end else state_d = IDLE;
                    end
                DATA: if (rx.se0) begin
                        state_d = EOP;
                        s0cnt_d = 2'd1;
                    end else if (viol) begin
                        state_d         = ERR;
                        s0cnt_d         = '0;
                        out_d.err_stuff = 1'b1;
                    end else if (dv && !drop) begin
                        bcnt_d          = bcnt_q + 3'd1;
                        out_d.bit_valid = 1'b1;
                        out_d.bit_out   = rx.dec_bit;
                    end
                EOP: if (rx.se0) s0cnt_d = (s0cnt_q == 2'd3) ? 2'd3 : s0cnt_q + 2'd1;
                    else if (rx.dec_valid) begin
                        if (s0cnt_q >= ESE0) begin
                            state_d         = IDLE;
                            out_d.pkt_done  = bcnt_q == 3'd0;
                            out_d.err_align = bcnt_q != 3'd0;
                        end else begin
                            state_d         = ERR;
                            s0cnt_d         = '0;
                            out_d.err_stuff = 1'b1;
                        end
                    end
                // s0cnt doubles as the "SE0 seen" flag while draining a bad packet
                ERR: if (rx.se0) s0cnt_d = 2'd1;
                    else if (rx.dec_valid && s0cnt_q != 2'd0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        out_d.busy = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            zcnt_q  <= '0;
            bcnt_q  <= '0;
            s0cnt_q <= '0;
            tcnt_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
            bcnt_q  <= bcnt_d;
            s0cnt_q <= s0cnt_d;
            tcnt_q  <= tcnt_d;
            out_q   <= out_d;
        end
    end
    assign rx.nrzi_clr  = out_q.nrzi_clr;
    assign rx.bit_out   = out_q.bit_out;
    assign rx.bit_valid = out_q.bit_valid;
    assign rx.pkt_start = out_q.pkt_start;
    assign rx.pkt_done  = out_q.pkt_done;
    assign rx.err_stuff = out_q.err_stuff;
    assign rx.err_align = out_q.err_align;
    assign rx.err_tmo   = out_q.err_tmo;
    assign rx.busy      = out_q.busy;
endmodule

// File: tb/tb_usb_rx_seq.sv
// tb_usb_rx_seq: directed scenarios for usb_rx_seq; a monitor tallies output pulses and payload bits.
module tb_usb_rx_seq;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic enable = 1'b1;
    int checks = 0;
    int errors = 0;
    int n_start, n_done, n_stuff, n_align, n_tmo, n_clr, n_bv;
    logic [31:0] bits;
    usb_rx_seq_if rx();
    usb_rx_seq dut (.clk(clk), .rst_b(rst_b), .enable(enable), .rx(rx));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        if (rx.pkt_start) n_start++;
        if (rx.pkt_done)  n_done++;
        if (rx.err_stuff) n_stuff++;
        if (rx.err_align) n_align++;
        if (rx.err_tmo)   n_tmo++;
        if (rx.nrzi_clr)  n_clr++;
        if (rx.bit_valid) begin
            n_bv++;
            bits = {rx.bit_out, bits[31:1]};
        end
    end
    function automatic logic [8:0] outs();
        return {rx.nrzi_clr, rx.bit_out, rx.bit_valid, rx.pkt_start, rx.pkt_done,
                rx.err_stuff, rx.err_align, rx.err_tmo, rx.busy};
    endfunction
    task automatic clear();
        @(negedge clk);
        {n_start, n_done, n_stuff, n_align, n_tmo, n_clr, n_bv} = '0;
        bits = '0;
    endtask
    task automatic send(input logic b, input logic s, input logic v);
        @(negedge clk);
        rx.dec_bit = b;
        rx.se0 = s;
        rx.dec_valid = v;
    endtask
    task automatic idle(input int n);
        repeat (n) send(1'b0, 1'b0, 1'b0);
    endtask
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) send(v[i], 1'b0, 1'b1);
    endtask
    task automatic send_sync();
        repeat (7) send(1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
    endtask
    task automatic send_eop();
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1);
    endtask
    task automatic test_reset();
        rx.dec_bit = 1'b0;
        rx.se0 = 1'b0;
        rx.dec_valid = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 9'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %09b expected %09b", outs(), 9'h000);
        end
        rst_b = 1'b1;
        idle(2);
        checks++;
        if (rx.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", rx.busy);
        end
    endtask
    task automatic test_basic();
        clear();
        send_sync();
        send_bits(32'hA5, 8);
        send_eop();
        idle(3);
        checks++;
        if (n_clr !== 1 || n_start !== 1) begin
            errors++;
            $display("FAIL basic_start: nrzi_clr=%0d pkt_start=%0d expected 1 1", n_clr, n_start);
        end
        checks++;
        if (n_bv !== 8 || bits[31:24] !== 8'hA5) begin
            errors++;
            $display("FAIL basic_payload: got %0d bits %02h expected 8 bits a5", n_bv, bits[31:24]);
        end
        checks++;
        if (n_done !== 1 || n_stuff + n_align + n_tmo !== 0 || rx.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%0d errs=%0d busy=%b expected 1 0 0", n_done, n_stuff + n_align + n_tmo, rx.busy);
        end
    endtask
    task automatic test_unstuff();
        clear();
        send_sync();
        send_bits(32'b110111111, 9);
        send_eop();
        idle(3);
        checks++;
        if (n_bv !== 8 || bits[31:24] !== 8'hFF) begin
            errors++;
            $display("FAIL unstuff_payload: got %0d bits %02h expected 8 bits ff", n_bv, bits[31:24]);
        end
        checks++;
        if (n_done !== 1 || n_stuff !== 0) begin
            errors++;
            $display("FAIL unstuff_done: done=%0d stuff=%0d expected 1 0", n_done, n_stuff);
        end
    endtask
    task automatic test_stuff_err();
        clear();
        send_sync();
        send_bits(32'h7F, 7);
        send_bits(32'h0, 3);
        idle(2);
        checks++;
        if (n_bv !== 6 || n_stuff !== 1) begin
            errors++;
            $display("FAIL stuff_err: bit_valid=%0d err_stuff=%0d expected 6 1", n_bv, n_stuff);
        end
        checks++;
        if (rx.busy !== 1'b1) begin
            errors++;
            $display("FAIL stuff_err_hold: busy got %b expected 1", rx.busy);
        end
        send_eop();
        idle(2);
        checks++;
        if (rx.busy !== 1'b0 || n_done + n_align + n_tmo !== 0 || n_stuff !== 1) begin
            errors++;
            $display("FAIL stuff_err_exit: busy=%b other=%0d stuff=%0d expected 0 0 1", rx.busy, n_done + n_align + n_tmo, n_stuff);
        end
    endtask
    task automatic test_align();
        clear();
        send_sync();
        send_bits(32'h6A5, 12);
        send_eop();
        idle(3);
        checks++;
        if (n_bv !== 12 || bits[31:20] !== 12'h6A5) begin
            errors++;
            $display("FAIL align_payload: got %0d bits %03h expected 12 bits 6a5", n_bv, bits[31:20]);
        end
        checks++;
        if (n_align !== 1 || n_done !== 0) begin
            errors++;
            $display("FAIL align_flag: align=%0d done=%0d expected 1 0", n_align, n_done);
        end
        clear();
        send_bits(32'b1000, 4);
        idle(3);
        checks++;
        if (n_start !== 0 || n_clr !== 1 || rx.busy !== 1'b0) begin
            errors++;
            $display("FAIL short_sync: start=%0d clr=%0d busy=%b expected 0 1 0", n_start, n_clr, rx.busy);
        end
    endtask
    task automatic test_timeout();
        clear();
        send_sync();
        send_bits(32'h5, 4);
        idle(255);
        checks++;
        if (n_tmo !== 0 || rx.busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early: err_tmo=%0d busy=%b expected 0 1", n_tmo, rx.busy);
        end
        idle(1);
        checks++;
        if (n_tmo !== 1 || rx.busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_fire: err_tmo=%0d busy=%b expected 1 1", n_tmo, rx.busy);
        end
        send_eop();
        idle(2);
        checks++;
        if (rx.busy !== 1'b0 || n_tmo !== 1 || n_done !== 0) begin
            errors++;
            $display("FAIL tmo_exit: busy=%b tmo=%0d done=%0d expected 0 1 0", rx.busy, n_tmo, n_done);
        end
    endtask
    task automatic test_enable();
        clear();
        send_sync();
        send_bits(32'h5, 4);
        @(negedge clk);
        rx.dec_valid = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (rx.busy !== 1'b0 || rx.bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_low: busy=%b bit_valid=%b expected 0 0", rx.busy, rx.bit_valid);
        end
        enable = 1'b1;
        idle(3);
        checks++;
        if (n_start !== 1 || n_done + n_stuff + n_align + n_tmo !== 0) begin
            errors++;
            $display("FAIL enable_flags: start=%0d flags=%0d expected 1 0", n_start, n_done + n_stuff + n_align + n_tmo);
        end
    endtask
    task automatic test_se0_dv();
        clear();
        send_sync();
        send_bits(32'b101, 3);
        send(1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        idle(3);
        checks++;
        if (n_bv !== 3 || n_align !== 1 || n_done + n_stuff !== 0) begin
            errors++;
            $display("FAIL se0_dv: bit_valid=%0d align=%0d other=%0d expected 3 1 0", n_bv, n_align, n_done + n_stuff);
        end
    endtask
    task automatic test_reset_mid();
        clear();
        send_sync();
        send_bits(32'b01, 2);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        checks++;
        if (outs() !== 9'h000) begin
            errors++;
            $display("FAIL reset_mid: got %09b expected %09b", outs(), 9'h000);
        end
        rx.dec_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        idle(3);
        checks++;
        if (n_done + n_stuff + n_align + n_tmo !== 0 || rx.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flags: flags=%0d busy=%b expected 0 0", n_done + n_stuff + n_align + n_tmo, rx.busy);
        end
    endtask
    task automatic test_back_to_back();
        clear();
        send_sync();
        send_bits(32'hA5, 8);
        send_eop();
        send_sync();
        send_bits(32'h3C, 8);
        send_eop();
        idle(3);
        checks++;
        if (n_start !== 2 || n_done !== 2 || n_clr !== 2) begin
            errors++;
            $display("FAIL b2b_count: start=%0d done=%0d clr=%0d expected 2 2 2", n_start, n_done, n_clr);
        end
        checks++;
        if (n_bv !== 16 || bits[31:16] !== 16'h3CA5) begin
            errors++;
            $display("FAIL b2b_payload: got %0d bits %04h expected 16 bits 3ca5", n_bv, bits[31:16]);
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_unstuff();
        test_stuff_err();
        test_align();
        test_timeout();
        test_enable();
        test_se0_dv();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
